// File: rtl/hamming_corrector.sv
// Serial extended Hamming (16,11) decoder: receives a 16-bit codeword bit by bit,
// corrects single-bit errors, flags double-bit errors and streams out the 11 data bits.
module hamming_corrector (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       datain,
  input  logic       din_valid,
  output logic       din_ready,
  output logic       dataout,
  output logic       dout_valid,
  output logic       dout_last,
  output logic       single_err,
  output logic       double_err,
  output logic [3:0] err_pos
);

  typedef enum logic [1:0] {RECV, CORR, SEND} state_t;

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg;
  logic [3:0]  syn_reg;
  logic        par_reg;
  logic [15:0] buf_reg;
  logic [3:0]  send_pos;

  // Codeword position of the idx-th data bit (parity lives at 0,1,2,4,8).
  function automatic logic [3:0] data_pos(input logic [3:0] idx);
    case (idx)
      4'd0:    data_pos = 4'd3;
      4'd1:    data_pos = 4'd5;
      4'd2:    data_pos = 4'd6;
      4'd3:    data_pos = 4'd7;
      4'd4:    data_pos = 4'd9;
      4'd5:    data_pos = 4'd10;
      4'd6:    data_pos = 4'd11;
      4'd7:    data_pos = 4'd12;
      4'd8:    data_pos = 4'd13;
      4'd9:    data_pos = 4'd14;
      default: data_pos = 4'd15;
    endcase
  endfunction

  assign send_pos = data_pos(cnt_reg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= RECV;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RECV:    if (din_valid && cnt_reg == 4'd15) state_next = CORR;
      CORR:    state_next = SEND;
      SEND:    if (cnt_reg == 4'd10) state_next = RECV;
      default: state_next = RECV;
    endcase
  end

  always_comb begin
    din_ready  = (state_reg == RECV);
    dout_valid = (state_reg == SEND);
    dout_last  = (state_reg == SEND) && (cnt_reg == 4'd10);
    dataout    = (state_reg == SEND) ? buf_reg[send_pos] : 1'b0;
  end

  // cnt_reg indexes the codeword in RECV and the data bit in SEND.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg    <= 4'd0;
      syn_reg    <= 4'd0;
      par_reg    <= 1'b0;
      buf_reg    <= 16'd0;
      single_err <= 1'b0;
      double_err <= 1'b0;
      err_pos    <= 4'd0;
    end else begin
      case (state_reg)
        RECV: begin
          if (din_valid) begin
            buf_reg[cnt_reg] <= datain;
            if (datain) syn_reg <= syn_reg ^ cnt_reg;
            par_reg <= par_reg ^ datain;
            cnt_reg <= cnt_reg + 4'd1;
          end
        end
        CORR: begin
          cnt_reg <= 4'd0;
          if (par_reg) begin
            buf_reg[syn_reg] <= ~buf_reg[syn_reg];
            single_err       <= 1'b1;
            double_err       <= 1'b0;
            err_pos          <= syn_reg;
          end else if (syn_reg != 4'd0) begin
            single_err <= 1'b0;
            double_err <= 1'b1;
            err_pos    <= 4'd0;
          end else begin
            single_err <= 1'b0;
            double_err <= 1'b0;
            err_pos    <= 4'd0;
          end
        end
        SEND: begin
          if (cnt_reg == 4'd10) begin
            cnt_reg <= 4'd0;
            syn_reg <= 4'd0;
            par_reg <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg + 4'd1;
          end
        end
        default: cnt_reg <= 4'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_hamming_corrector.sv
// Directed-vector bench for hamming_corrector: clean, single-error and double-error
// codewords, input gaps, and a reset that aborts a partially received block.
module tb_hamming_corrector;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       datain = 1'b0;
  logic       din_valid = 1'b0;
  logic       din_ready;
  logic       dataout;
  logic       dout_valid;
  logic       dout_last;
  logic       single_err;
  logic       double_err;
  logic [3:0] err_pos;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hamming_corrector dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .datain    (datain),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .dataout   (dataout),
    .dout_valid(dout_valid),
    .dout_last (dout_last),
    .single_err(single_err),
    .double_err(double_err),
    .err_pos   (err_pos)
  );

  typedef struct {
    string       name;
    logic [15:0] cw;
    logic [10:0] exp_data;   // bit k = k-th serial data bit
    logic        exp_single;
    logic        exp_double;
    logic [3:0]  exp_pos;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_block(input logic [15:0] cw, input bit gaps);
    for (int i = 0; i < 16; i++) begin
      if (gaps) begin
        int g;
        g = $urandom_range(0, 3);
        repeat (g) begin
          @(negedge clk);
          din_valid = 1'b0;
          datain    = 1'($urandom);
        end
      end
      @(negedge clk);
      din_valid = 1'b1;
      datain    = cw[i];
    end
  endtask

  // Called right after the last codeword bit has been driven.
  task automatic collect(input vec_t v, input string tag);
    int          n;
    logic [10:0] got;
    logic [10:0] lastv;
    logic [10:0] validv;
    @(negedge clk);
    din_valid = 1'b1;
    datain    = 1'b1;
    check({tag, ".corr_ready"}, 16'(din_ready), 16'd0);
    check({tag, ".corr_dout"}, 16'({dout_valid, dataout}), 16'd0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!dout_valid && n < 20);
    check({tag, ".latency"}, 16'(n), 16'd1);
    got = '0; lastv = '0; validv = '0;
    for (int k = 0; k < 11; k++) begin
      if (k > 0) @(negedge clk);
      got[k]    = dataout;
      lastv[k]  = dout_last;
      validv[k] = dout_valid;
      datain    = 1'($urandom);
    end
    check({tag, ".data"}, 16'(got), 16'(v.exp_data));
    check({tag, ".last"}, 16'(lastv), 16'h400);
    check({tag, ".valid"}, 16'(validv), 16'h7ff);
    check({tag, ".flags"}, 16'({single_err, double_err, err_pos}),
          16'({v.exp_single, v.exp_double, v.exp_pos}));
    @(negedge clk);
    din_valid = 1'b0;
    check({tag, ".idle"}, 16'({din_ready, dout_valid, dout_last, dataout}), 16'b1000);
    check({tag, ".hold"}, 16'({single_err, double_err, err_pos}),
          16'({v.exp_single, v.exp_double, v.exp_pos}));
    $display("block %s cw=0x%04h data=0x%03h single=%0b double=%0b pos=%0d",
             tag, v.cw, got, single_err, double_err, err_pos);
  endtask

  initial begin
    vecs[0] = '{"zero",      16'h0000, 11'h000, 1'b0, 1'b0, 4'd0};
    vecs[1] = '{"ones0123",  16'h000F, 11'h001, 1'b0, 1'b0, 4'd0};
    vecs[2] = '{"flip12",    16'h1000, 11'h000, 1'b1, 1'b0, 4'd12};
    vecs[3] = '{"flip0",     16'h0001, 11'h000, 1'b1, 1'b0, 4'd0};
    vecs[4] = '{"dbl3_5",    16'h0028, 11'h003, 1'b0, 1'b1, 4'd0};
    vecs[5] = '{"d5clean",   16'h0033, 11'h002, 1'b0, 1'b0, 4'd0};
    vecs[6] = '{"d5flip15",  16'h8033, 11'h002, 1'b1, 1'b0, 4'd15};
    vecs[7] = '{"flip7",     16'h0080, 11'h000, 1'b1, 1'b0, 4'd7};

    repeat (2) @(negedge clk);
    check("reset.outputs",
          16'({din_ready, dataout, dout_valid, dout_last, single_err, double_err, err_pos}),
          16'b100_0000_000);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      send_block(vecs[i].cw, 1'b0);
      collect(vecs[i], vecs[i].name);
    end

    // Gapped delivery must give the same result as gap-free delivery.
    send_block(vecs[5].cw, 1'b1);
    collect(vecs[5], "gap_d5clean");
    send_block(vecs[6].cw, 1'b1);
    collect(vecs[6], "gap_d5flip15");

    // Abort a block after 7 ones (flags still set from the previous block).
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      din_valid = 1'b1;
      datain    = 1'b1;
    end
    @(negedge clk);
    din_valid = 1'b0;
    rst_n     = 1'b0;
    #1;
    check("midreset.outputs",
          16'({din_ready, dataout, dout_valid, dout_last, single_err, double_err, err_pos}),
          16'b100_0000_000);
    @(negedge clk);
    rst_n = 1'b1;
    send_block(vecs[0].cw, 1'b0);
    collect(vecs[0], "after_reset_zero");
    send_block(vecs[1].cw, 1'b1);
    collect(vecs[1], "after_reset_ones0123");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
